// File: rtl/fault_tolerant_fir.sv
// -----------------------------------------------------------------------------
// fault_tolerant_fir
//
// N-modular-redundant direct-form FIR filter. NMR_N identical replicas share
// one coefficient write port and one sample input. Each replica keeps its own
// coefficient bank and delay line. A bitwise majority voter combines the
// scaled replica results, so any value in a minority of replicas is masked.
//
// Handshake: there is none. A sample is taken from u_in on every rising edge
// with rst=1, and a coefficient is written on every such edge with we_in=1.
// y_out is registered and updates on every edge.
//
// Ports
//   clk           in   1       system clock, all state on rising edge
//   rst           in   1       synchronous reset, active-low
//   u_in          in   WIDTH   signed input sample, Q1.(WIDTH-1)
//   coef_addr_in  in   ADDR_W  coefficient index 0..FIR_ORD (others ignored)
//   coef_in       in   WIDTH   signed coefficient value, Q1.(WIDTH-1)
//   we_in         in   1       coefficient write enable
//   y_out         out  WIDTH   voted signed filter output, Q1.(WIDTH-1)
// -----------------------------------------------------------------------------
module fault_tolerant_fir #(
  parameter int NMR_N   = 3,
  parameter int FIR_ORD = 5,
  parameter int WIDTH   = 24,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  u_in,
  input  logic [ADDR_W-1:0] coef_addr_in,
  input  logic [WIDTH-1:0]  coef_in,
  input  logic              we_in,
  output logic [WIDTH-1:0]  y_out
);

  localparam int TAPS   = FIR_ORD + 1;
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(FIR_ORD);

  // Writes to addresses beyond the last tap are dropped.
  logic coef_wr_ok;
  assign coef_wr_ok = we_in && (coef_addr_in <= MAX_ADDR);

  // Scaled result of every replica, one WIDTH-bit slice per replica.
  logic [NMR_N-1:0][WIDTH-1:0] s_all;

  for (genvar r = 0; r < NMR_N; r++) begin : gen_rep
    logic signed [WIDTH-1:0] c_q [TAPS];
    logic signed [WIDTH-1:0] x_q [TAPS];
    logic signed [ACC_W-1:0] acc;
    logic        [WIDTH-1:0] s_r;
    logic                    unused_acc_bits;

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k < TAPS; k++) begin
          c_q[k] <= '0;
          x_q[k] <= '0;
        end
      end else begin
        x_q[0] <= u_in;
        for (int k = 1; k < TAPS; k++) begin
          x_q[k] <= x_q[k-1];
        end
        if (coef_wr_ok) begin
          c_q[coef_addr_in] <= coef_in;
        end
      end
    end

    // Full-precision signed products summed in a guard-bit accumulator.
    always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
        acc = acc + ACC_W'(PROD_W'(c_q[k]) * PROD_W'(x_q[k]));
      end
    end

    // Arithmetic shift right by WIDTH-1 then truncation to WIDTH bits is the
    // same as picking this bit window; the output wraps, no rounding.
    assign s_r = acc[WIDTH-1 +: WIDTH];
    assign unused_acc_bits = ^{acc[ACC_W-1:PROD_W-1], acc[WIDTH-2:0]};
    assign s_all[r] = s_r;
  end

  // Bitwise majority across replicas.
  logic [WIDTH-1:0] vote;
  int               ones_cnt;

  always_comb begin
    vote     = '0;
    ones_cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = 0;
      for (int r = 0; r < NMR_N; r++) begin
        ones_cnt = ones_cnt + int'(s_all[r][i]);
      end
      vote[i] = (ones_cnt > (NMR_N / 2));
    end
  end

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;

  assign y_d = vote;

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: tb/tb_fault_tolerant_fir.sv
// -----------------------------------------------------------------------------
// tb_fault_tolerant_fir
//
// Randomized and directed stimulus for fault_tolerant_fir (3 replicas, order 5,
// 24-bit). A behavioural model (integer arithmetic on arrays of coefficients
// and past samples) predicts y_out for every edge; predictions go into an
// expected queue that a compare process drains one entry per cycle. Directed
// phases also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_fault_tolerant_fir;

  localparam int W    = 24;
  localparam int TAPS = 6;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic [W-1:0]  u_in;
  logic [2:0]    coef_addr_in;
  logic [W-1:0]  coef_in;
  logic          we_in;
  logic [W-1:0]  y_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fault_tolerant_fir #(
    .NMR_N(3), .FIR_ORD(5), .WIDTH(24), .ADDR_W(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .u_in         (u_in),
    .coef_addr_in (coef_addr_in),
    .coef_in      (coef_in),
    .we_in        (we_in),
    .y_out        (y_out)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint cm [TAPS];
  longint xm [TAPS];
  logic [2:0]   f_en;
  logic [W-1:0] fv0, fv1, fv2;
  logic [W-1:0] last_exp;

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [W-1:0] model_s();
    longint sum;
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += cm[k] * xm[k];
    return W'(sum >>> (W - 1));
  endfunction

  // Fault injection overrides a replica's scaled result.
  task automatic apply_faults();
    if (f_en[0]) force dut.gen_rep[0].s_r = fv0; else release dut.gen_rep[0].s_r;
    if (f_en[1]) force dut.gen_rep[1].s_r = fv1; else release dut.gen_rep[1].s_r;
    if (f_en[2]) force dut.gen_rep[2].s_r = fv2; else release dut.gen_rep[2].s_r;
  endtask

  task automatic clear_faults();
    f_en = 3'b000;
    apply_faults();
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rv, input logic [W-1:0] u, input logic w,
                       input logic [2:0] a, input logic [W-1:0] cf);
    logic [W-1:0] s, r0, r1, r2, e;
    rst = rv; u_in = u; we_in = w; coef_addr_in = a; coef_in = cf;
    s  = model_s();
    r0 = f_en[0] ? fv0 : s;
    r1 = f_en[1] ? fv1 : s;
    r2 = f_en[2] ? fv2 : s;
    e  = rv ? ((r0 & r1) | (r0 & r2) | (r1 & r2)) : '0;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    if (!rv) begin
      for (int k = 0; k < TAPS; k++) begin cm[k] = 0; xm[k] = 0; end
    end else begin
      for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
      xm[0] = sx(u);
      if (w && a < 3'(TAPS)) cm[a] = sx(cf);
    end
    #4;
  endtask

  task automatic load_all(input logic [W-1:0] cf, input logic [W-1:0] u);
    for (int k = 0; k < TAPS; k++) cycle(1'b1, u, 1'b1, 3'(k), cf);
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("y_out_vs_model", y_out, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; u_in = '0; we_in = 1'b0; coef_addr_in = '0; coef_in = '0;
    f_en = 3'b000; fv0 = '0; fv1 = '0; fv2 = '0; last_exp = '0;
    for (int k = 0; k < TAPS; k++) begin cm[k] = 0; xm[k] = 0; end

    // Reset with a non-zero sample present, then run with no coefficients.
    cycle(1'b0, 24'h123456, 1'b0, 3'd0, 24'h0);
    cycle(1'b0, 24'h123456, 1'b0, 3'd0, 24'h0);
    check("reset_y", y_out, 24'h000000);
    for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), 1'b0, 3'd0, 24'h0);
    check("no_coef_y", y_out, 24'h000000);

    // Impulse: every tap 0.5, one sample of 0.5.
    load_all(24'h400000, 24'h0);
    cycle(1'b1, 24'h400000, 1'b0, 3'd0, 24'h0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 24'h0, 1'b0, 3'd0, 24'h0);
      check($sformatf("impulse_%0d", i), y_out, (i <= 6) ? 24'h200000 : 24'h000000);
    end

    // Step: every tap 0.125, input held at 0.5.
    load_all(24'h100000, 24'h0);
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 24'h400000, 1'b0, 3'd0, 24'h0);
      if (i == 2) check("step_2", y_out, 24'h080000);
      if (i == 3) check("step_3", y_out, 24'h100000);
      if (i >= 7) check($sformatf("step_%0d", i), y_out, 24'h300000);
    end
    check("model_step_pin", last_exp, 24'h300000);

    // Single replica fault is masked.
    fv1 = 24'h7FFFFF; f_en = 3'b010; apply_faults();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 24'h400000, 1'b0, 3'd0, 24'h0);
      check("mask_single", y_out, 24'h300000);
    end
    // All replicas disagree: per-bit majority is zero.
    fv0 = 24'h0000FF; fv1 = 24'h000000; fv2 = 24'h00FF00; f_en = 3'b111; apply_faults();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 24'h400000, 1'b0, 3'd0, 24'h0);
      check("majority_bits", y_out, 24'h000000);
    end
    clear_faults();
    cycle(1'b1, 24'h400000, 1'b0, 3'd0, 24'h0);
    check("fault_release", y_out, 24'h300000);

    // Sign: c0=0.5, others 0, u=-0.5 -> -0.25; out-of-range writes ignored.
    cycle(1'b1, 24'hC00000, 1'b1, 3'd0, 24'h400000);
    for (int k = 1; k < TAPS; k++) cycle(1'b1, 24'hC00000, 1'b1, 3'(k), 24'h0);
    cycle(1'b1, 24'hC00000, 1'b1, 3'd6, 24'h7FFFFF);
    cycle(1'b1, 24'hC00000, 1'b1, 3'd7, 24'h7FFFFF);
    check("sign_y", y_out, 24'hE00000);
    cycle(1'b1, 24'hC00000, 1'b0, 3'd0, 24'h0);
    check("sign_after_bad_addr", y_out, 24'hE00000);
    check("model_sign_pin", last_exp, 24'hE00000);

    // Mid-stream coefficient rewrite, then a one-edge reset.
    for (int k = 0; k < TAPS; k++) cycle(1'b1, W'($urandom), 1'b1, 3'(k), W'($urandom));
    for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), 1'b0, 3'd0, 24'h0);
    cycle(1'b1, W'($urandom), 1'b1, 3'd0, 24'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom), 1'b0, 3'd0, 24'h0);
    cycle(1'b0, W'($urandom), 1'b1, 3'd2, 24'h7FFFFF);
    check("midstream_reset", y_out, 24'h000000);

    // Random traffic with occasional writes, resets and single faults.
    for (int i = 0; i < 400; i++) begin
      logic         rv, w;
      logic [2:0]   a;
      int           sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        clear_faults();
      end else if (sel == 1) begin
        clear_faults();
        case ($urandom_range(0, 2))
          0: begin fv0 = W'($urandom); f_en = 3'b001; end
          1: begin fv1 = W'($urandom); f_en = 3'b010; end
          default: begin fv2 = W'($urandom); f_en = 3'b100; end
        endcase
        apply_faults();
      end
      rv = ($urandom_range(0, 49) != 0);
      w  = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      cycle(rv, W'($urandom), w, a, W'($urandom));
    end
    clear_faults();
    cycle(1'b1, 24'h0, 1'b0, 3'd0, 24'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
